// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and
// holds the IF/ID pipeline register. Redirects come from branches (with a
// one-instruction delay slot), from branches remembered across a stall, and
// from exception flushes. A misaligned redirect target parks the stage in
// HALT until an aligned flush arrives.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic [31:0] rom_inst_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rom_ce_q, rom_ce_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Scratch values for the redirect decision of the current cycle.
    logic        redirect;
    logic [31:0] redirect_target;

    // Next-state logic: flush beats stall, stall beats branch, branch beats PC+4.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        id_pc_d         = id_pc_q;
        id_inst_d       = id_inst_q;
        id_valid_d      = id_valid_q;
        misalign_d      = misalign_q;
        fetch_cnt_d     = fetch_cnt_q;
        pend_valid_d    = pend_valid_q;
        pend_target_d   = pend_target_q;
        redirect        = 1'b0;
        redirect_target = 32'h0000_0000;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            default: begin
                if (flush_i) begin
                    id_inst_d       = 32'h0000_0000;
                    id_valid_d      = 1'b0;
                    pend_valid_d    = 1'b0;
                    state_d         = RUN;
                    redirect        = 1'b1;
                    redirect_target = new_pc_i;
                end else if (state_q == HALT) begin
                    id_inst_d  = 32'h0000_0000;
                    id_valid_d = 1'b0;
                end else if (stall_i) begin
                    state_d = STALL;
                    if (branch_flag_i) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = branch_target_i;
                    end
                end else begin
                    id_pc_d      = pc_q;
                    id_inst_d    = rom_inst_i;
                    id_valid_d   = 1'b1;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                    if (pend_valid_q) begin
                        redirect        = 1'b1;
                        redirect_target = pend_target_q;
                    end else if (branch_flag_i) begin
                        redirect        = 1'b1;
                        redirect_target = branch_target_i;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
        endcase

        if (redirect) begin
            pc_d = redirect_target;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = HALT;
            end
        end

        rom_ce_d = (state_d == RUN) || (state_d == STALL);
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= 32'h0000_0000;
            rom_ce_q      <= 1'b0;
            id_pc_q       <= 32'h0000_0000;
            id_inst_q     <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_cnt_q   <= 32'h0000_0000;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_ce_q      <= rom_ce_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
            fetch_cnt_q   <= fetch_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign rom_ce_o    = rom_ce_q;
    assign rom_addr_o  = pc_q;
    assign id_pc_o     = id_pc_q;
    assign id_inst_o   = id_inst_q;
    assign id_valid_o  = id_valid_q;
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule
